ps2_mouse_packet_decoder: RTL and testbench
===========================================

Name: ps2_mouse_packet_decoder

Overview:
Sits directly downstream of the PS/2 mouse receive path, once the mouse is in streaming mode (after the F4 command). Consumes received bytes one at a time and frames them into standard 3-byte mouse packets (status, dX, dY). Decodes button states and signed motion, and accumulates a clamped cursor position for the VGA/home-simulation logic. Recovers framing automatically after line glitches, parity errors or stalls.

Parameters:
SCREEN_W, 160, cursor x range 0..SCREEN_W-1
SCREEN_H, 120, cursor y range 0..SCREEN_H-1
XW, 8, cursor_x width
YW, 7, cursor_y width
TIMEOUT_CYCLES, 100000, max clk_50 cycles between bytes of one packet (2 ms at 50 MHz)

Ports:
clk_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
byte_data  in  8  received PS/2 byte, valid only when byte_valid=1
byte_valid  in  1  one-cycle strobe per received byte
parity_err  in  1  qualifies byte_valid: the byte failed parity/stop check
recenter  in  1  synchronous request to move the cursor to the screen centre
cursor_x  out  XW  accumulated cursor x
cursor_y  out  YW  accumulated cursor y, 0 = top of screen
btn_left / btn_right / btn_middle  out  1 each  button state from the last packet
dx / dy  out  9  signed motion from the last packet, two's complement
x_ovf / y_ovf  out  1 each  overflow bits from the last packet
packet_valid  out  1  one-cycle strobe: new packet committed
sync_err  out  1  one-cycle strobe: byte or partial packet discarded

Behaviour:
- One clock, clk_50. Reset is synchronous and active-high.
- Reset values:
  - cursor_x = SCREEN_W/2 (80), cursor_y = SCREEN_H/2 (60).
  - All buttons, dx, dy, x_ovf, y_ovf, packet_valid and sync_err = 0.
  - FSM = WAIT_B0; timeout counter = 0.
- Reset asserted mid-packet discards the partial packet. No packet_valid or sync_err pulse results.
- FSM states and transitions:
  - WAIT_B0, byte_valid with parity_err=0 and byte_data[3]=1: latch byte as status; go to WAIT_B1.
  - WAIT_B0, byte_valid with parity_err=1 or bit3=0: discard byte; pulse sync_err next cycle; stay in WAIT_B0.
  - WAIT_B1, byte_valid with parity_err=0: latch byte as dX low; go to WAIT_B2.
  - WAIT_B2, byte_valid with parity_err=0: latch byte as dY low; commit the packet; go to WAIT_B0.
  - WAIT_B1/WAIT_B2, byte_valid with parity_err=1: discard the partial packet; pulse sync_err; go to WAIT_B0.
- Timeout:
  - The counter clears on every accepted byte and in WAIT_B0.
  - In WAIT_B1/WAIT_B2 it increments each cycle without byte_valid.
  - On reaching TIMEOUT_CYCLES-1: discard the partial packet, pulse sync_err, go to WAIT_B0.
  - If byte_valid arrives in that same cycle, the byte wins and no timeout occurs.
- Commit, with latency = 1 cycle after the third byte_valid. All outputs below update together with packet_valid=1:
  - dx = {status[4], b1}; dy = {status[5], b2}.
  - x_ovf = status[6]; y_ovf = status[7].
  - btn_left = status[0], btn_right = status[1], btn_middle = status[2].
- Position arithmetic:
  - Signed 12-bit intermediate values.
  - x_next = cursor_x + dx; y_next = cursor_y - dy (PS/2 +Y is up).
  - Each axis is clamped to [0, SCREEN_W-1] / [0, SCREEN_H-1].
  - An axis with its overflow bit set contributes zero motion. dx/dy still report the raw value.
- recenter:
  - Sets the cursor to the centre on the next cycle.
  - If it coincides with a commit, centre wins for position. Buttons, dx and dy still update and packet_valid still pulses.
- Throughput: a byte is accepted every cycle, including the cycle in which packet_valid or sync_err is asserted.
- sync_err and packet_valid are never asserted in the same cycle.

Test Plan:
1. Reset, then bytes 08,05,03 -> packet_valid 1 cycle after the 3rd byte; dx=+5, dy=+3, cursor=(85,57), buttons 0.
2. Bytes 19,FB,00 (left button, dx=-5) -> btn_left=1, dx=0x1FB, cursor_x=75; then 28,00,F6 (dy=-10) -> cursor_y=70.
3. Clamping: from (80,60) send 08,7F,00 -> cursor_x=159 (clamped, not wrapped); send 18,80,00 twice -> cursor_x=0, no underflow wrap.
4. Resync: send 05 (bit3=0) -> sync_err pulse, no commit; then 08,01,01 -> commit with cursor=(81,59).
5. Timeout: send 08, wait TIMEOUT_CYCLES+5 idle cycles -> sync_err pulse; then 08,02,00 -> commit dx=+2. Parity: 08 then a byte with parity_err=1 -> sync_err, back to WAIT_B0.
6. Overflow/recenter: 48,10,00 -> x_ovf=1, dx=0x010, cursor_x unchanged. Then recenter=1 coincident with the commit of 09,10,10 -> cursor=(80,60), btn_left=1.

Source files
------------

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder
// Frames a stream-mode PS/2 mouse byte stream into 3-byte packets
// (status, dX, dY), decodes buttons and signed motion, and integrates a
// clamped cursor position. Framing recovers automatically on a bad status
// byte, a parity error or an inter-byte timeout.
//
// Ports
//   clk_50        system clock
//   reset         synchronous, active-high reset
//   byte_data     received byte, qualified by byte_valid
//   byte_valid    one-cycle strobe per received byte
//   parity_err    qualifies byte_valid: byte failed parity/stop check
//   recenter      move the cursor to the screen centre next cycle
//   cursor_x/y    accumulated cursor position (y = 0 is top of screen)
//   btn_*         button state from the last packet
//   dx/dy         raw 9-bit two's complement motion from the last packet
//   x_ovf/y_ovf   overflow bits from the last packet
//   packet_valid  one-cycle strobe: new packet committed
//   sync_err      one-cycle strobe: byte or partial packet discarded
module ps2_mouse_packet_decoder #(
    parameter int unsigned SCREEN_W       = 160,
    parameter int unsigned SCREEN_H       = 120,
    parameter int unsigned XW             = 8,
    parameter int unsigned YW             = 7,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          clk_50,
    input  logic          reset,
    input  logic [7:0]    byte_data,
    input  logic          byte_valid,
    input  logic          parity_err,
    input  logic          recenter,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          btn_left,
    output logic          btn_right,
    output logic          btn_middle,
    output logic [8:0]    dx,
    output logic [8:0]    dy,
    output logic          x_ovf,
    output logic          y_ovf,
    output logic          packet_valid,
    output logic          sync_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);
    localparam logic [XW-1:0] X_CENTRE = XW'(SCREEN_W / 2);
    localparam logic [YW-1:0] Y_CENTRE = YW'(SCREEN_H / 2);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timeout_cnt;

    // Latched status fields (bit 3 is the always-one sync bit, not kept).
    logic [2:0] s_btn;
    logic       s_xsign;
    logic       s_ysign;
    logic       s_xovf;
    logic       s_yovf;
    logic [7:0] b1;

    // Commit-time values, computed from the latched bytes plus the dY byte.
    logic [8:0]        dx_new;
    logic [8:0]        dy_new;
    logic signed [11:0] x_base, x_step, x_sum;
    logic signed [11:0] y_base, y_step, y_sum;
    logic [XW-1:0]     x_next;
    logic [YW-1:0]     y_next;

    // Position update: sign-extend motion, skip an overflowed axis, clamp.
    always_comb begin
        dx_new = {s_xsign, b1};
        dy_new = {s_ysign, byte_data};
        x_base = 12'(cursor_x);
        y_base = 12'(cursor_y);
        x_step = s_xovf ? 12'sd0 : {{3{dx_new[8]}}, dx_new};
        y_step = s_yovf ? 12'sd0 : {{3{dy_new[8]}}, dy_new};
        x_sum  = x_base + x_step;
        y_sum  = y_base - y_step;   // PS/2 +Y is up, screen y grows down

        if (x_sum < 12'sd0) begin
            x_next = '0;
        end else if (x_sum > X_MAX) begin
            x_next = XW'(X_MAX);
        end else begin
            x_next = XW'(x_sum);
        end

        if (y_sum < 12'sd0) begin
            y_next = '0;
        end else if (y_sum > Y_MAX) begin
            y_next = YW'(Y_MAX);
        end else begin
            y_next = YW'(y_sum);
        end
    end

    // Framing FSM, timeout counter and registered outputs.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state        <= WAIT_B0;
            timeout_cnt  <= '0;
            s_btn        <= '0;
            s_xsign      <= 1'b0;
            s_ysign      <= 1'b0;
            s_xovf       <= 1'b0;
            s_yovf       <= 1'b0;
            b1           <= '0;
            cursor_x     <= X_CENTRE;
            cursor_y     <= Y_CENTRE;
            btn_left     <= 1'b0;
            btn_right    <= 1'b0;
            btn_middle   <= 1'b0;
            dx           <= '0;
            dy           <= '0;
            x_ovf        <= 1'b0;
            y_ovf        <= 1'b0;
            packet_valid <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            sync_err     <= 1'b0;

            case (state)
                WAIT_B0: begin
                    timeout_cnt <= '0;
                    if (byte_valid) begin
                        if (!parity_err && byte_data[3]) begin
                            s_btn   <= byte_data[2:0];
                            s_xsign <= byte_data[4];
                            s_ysign <= byte_data[5];
                            s_xovf  <= byte_data[6];
                            s_yovf  <= byte_data[7];
                            state   <= WAIT_B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end

                WAIT_B1, WAIT_B2: begin
                    if (byte_valid) begin
                        timeout_cnt <= '0;
                        if (parity_err) begin
                            sync_err <= 1'b1;
                            state    <= WAIT_B0;
                        end else if (state == WAIT_B1) begin
                            b1    <= byte_data;
                            state <= WAIT_B2;
                        end else begin
                            dx           <= dx_new;
                            dy           <= dy_new;
                            x_ovf        <= s_xovf;
                            y_ovf        <= s_yovf;
                            btn_left     <= s_btn[0];
                            btn_right    <= s_btn[1];
                            btn_middle   <= s_btn[2];
                            cursor_x     <= x_next;
                            cursor_y     <= y_next;
                            packet_valid <= 1'b1;
                            state        <= WAIT_B0;
                        end
                    end else if (timeout_cnt == CNT_LAST) begin
                        // Stalled mid-packet: drop it and resynchronise.
                        timeout_cnt <= '0;
                        sync_err    <= 1'b1;
                        state       <= WAIT_B0;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    timeout_cnt <= '0;
                    state       <= WAIT_B0;
                end
            endcase

            // Recenter overrides any same-cycle commit for position only.
            if (recenter) begin
                cursor_x <= X_CENTRE;
                cursor_y <= Y_CENTRE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed testbench for ps2_mouse_packet_decoder. Inputs change and
// outputs are sampled on the falling edge of clk_50.
module tb_ps2_mouse_packet_decoder;

    localparam int unsigned TO = 40;

    logic       clk_50 = 1'b0;
    logic       reset;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       parity_err;
    logic       recenter;
    logic [7:0] cursor_x;
    logic [6:0] cursor_y;
    logic       btn_left, btn_right, btn_middle;
    logic [8:0] dx, dy;
    logic       x_ovf, y_ovf;
    logic       packet_valid, sync_err;

    int n_checks = 0;
    int n_errors = 0;

    ps2_mouse_packet_decoder #(
        .SCREEN_W      (160),
        .SCREEN_H      (120),
        .XW            (8),
        .YW            (7),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .parity_err  (parity_err),
        .recenter    (recenter),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_middle  (btn_middle),
        .dx          (dx),
        .dy          (dy),
        .x_ovf       (x_ovf),
        .y_ovf       (y_ovf),
        .packet_valid(packet_valid),
        .sync_err    (sync_err)
    );

    always #10 clk_50 = ~clk_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] d, input logic pe);
        byte_data  = d;
        byte_valid = 1'b1;
        parity_err = pe;
        @(negedge clk_50);
        byte_valid = 1'b0;
        parity_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        reset = 1'b1;
        @(negedge clk_50);
        @(negedge clk_50);
        reset = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
    endtask

    initial begin
        int pulses;
        int commits;
        reset      = 1'b1;
        byte_data  = '0;
        byte_valid = 1'b0;
        parity_err = 1'b0;
        recenter   = 1'b0;
        do_reset();

        // Reset state
        check("rst_cx", 32'(cursor_x), 80);
        check("rst_cy", 32'(cursor_y), 60);
        check("rst_btn", {29'd0, btn_middle, btn_right, btn_left}, 0);
        check("rst_dxdy", {14'd0, dx, dy}, 0);
        check("rst_strobes", {28'd0, x_ovf, y_ovf, packet_valid, sync_err}, 0);

        // 1: basic packet
        send_packet(8'h08, 8'h05, 8'h03);
        check("t1_pv", 32'(packet_valid), 1);
        check("t1_dx", 32'(dx), 32'h005);
        check("t1_dy", 32'(dy), 32'h003);
        check("t1_cx", 32'(cursor_x), 85);
        check("t1_cy", 32'(cursor_y), 57);
        check("t1_btn", {29'd0, btn_middle, btn_right, btn_left}, 0);
        @(negedge clk_50);
        check("t1_pv_pulse", 32'(packet_valid), 0);

        // 2: left button + negative dx, then negative dy
        do_reset();
        send_packet(8'h19, 8'hFB, 8'h00);
        check("t2_btnl", 32'(btn_left), 1);
        check("t2_dx", 32'(dx), 32'h1FB);
        check("t2_cx", 32'(cursor_x), 75);
        check("t2_cy", 32'(cursor_y), 60);
        send_packet(8'h28, 8'h00, 8'hF6);
        check("t2_dy", 32'(dy), 32'h1F6);
        check("t2_cy2", 32'(cursor_y), 70);
        check("t2_btnl2", 32'(btn_left), 0);

        // 3: clamping at both x edges
        do_reset();
        send_packet(8'h08, 8'h7F, 8'h00);
        check("t3_cx_hi", 32'(cursor_x), 159);
        send_packet(8'h18, 8'h80, 8'h00);
        check("t3_dx_neg", 32'(dx), 32'h180);
        check("t3_cx_mid", 32'(cursor_x), 31);
        send_packet(8'h18, 8'h80, 8'h00);
        check("t3_cx_lo", 32'(cursor_x), 0);

        // 4: bad status byte resync; reset mid-packet discards silently
        do_reset();
        send_byte(8'h05, 1'b0);
        check("t4_serr", 32'(sync_err), 1);
        check("t4_no_pv", 32'(packet_valid), 0);
        send_packet(8'h08, 8'h01, 8'h01);
        check("t4_pv", 32'(packet_valid), 1);
        check("t4_serr_clr", 32'(sync_err), 0);
        check("t4_cxy", {cursor_x, 1'b0, cursor_y}, {8'd81, 1'b0, 7'd59});
        send_byte(8'h08, 1'b0);
        send_byte(8'h01, 1'b0);
        reset = 1'b1;
        @(negedge clk_50);
        reset = 1'b0;
        check("t4_rst_strobes", {30'd0, packet_valid, sync_err}, 0);
        send_byte(8'h03, 1'b0);   // would complete the old packet; must be a bad status now
        check("t4_rst_discard", {30'd0, packet_valid, sync_err}, 32'd1);
        send_packet(8'h08, 8'h01, 8'h01);
        check("t4_rst_cxy", {cursor_x, 1'b0, cursor_y}, {8'd81, 1'b0, 7'd59});

        // 5: inter-byte timeout, then parity error mid-packet
        do_reset();
        send_byte(8'h08, 1'b0);
        pulses  = 0;
        commits = 0;
        for (int i = 0; i < int'(TO) + 5; i++) begin
            @(negedge clk_50);
            if (sync_err) pulses++;
            if (packet_valid) commits++;
        end
        check("t5_to_pulses", 32'(pulses), 1);
        check("t5_to_commits", 32'(commits), 0);
        send_packet(8'h08, 8'h02, 8'h00);
        check("t5_pv", 32'(packet_valid), 1);
        check("t5_dx", 32'(dx), 32'h002);
        check("t5_cx", 32'(cursor_x), 82);
        send_byte(8'h08, 1'b0);
        send_byte(8'h33, 1'b1);
        check("t5_par_serr", 32'(sync_err), 1);
        send_packet(8'h08, 8'h01, 8'h00);
        check("t5_par_resync", {23'd0, packet_valid, cursor_x}, {23'd0, 1'b1, 8'd83});

        // 6: overflowed axis ignored, recenter wins over commit
        do_reset();
        send_packet(8'h48, 8'h10, 8'h00);
        check("t6_xovf", 32'(x_ovf), 1);
        check("t6_dx", 32'(dx), 32'h010);
        check("t6_cx", 32'(cursor_x), 80);
        send_byte(8'h09, 1'b0);
        send_byte(8'h10, 1'b0);
        recenter = 1'b1;
        send_byte(8'h10, 1'b0);
        recenter = 1'b0;
        check("t6_rc_pv", 32'(packet_valid), 1);
        check("t6_rc_cxy", {cursor_x, 1'b0, cursor_y}, {8'd80, 1'b0, 7'd60});
        check("t6_rc_btnl", 32'(btn_left), 1);
        check("t6_rc_dxdy", {14'd0, dx, dy}, {14'd0, 9'h010, 9'h010});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
